// File: rtl/grid_link_pkg.sv
// grid_link_pkg: shared types and constants for the grid serial link controller.
// Holds the host op encoding, the controller state encoding and the RUN count width.
package grid_link_pkg;
    localparam int RUN_W = 16;

    typedef enum logic [1:0] {
        OP_LOAD    = 2'd0,
        OP_RUN     = 2'd1,
        OP_READ    = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_READ  = 3'd3,
        S_DRAIN = 3'd4,
        S_RESP  = 3'd5
    } state_e;
endpackage

// File: rtl/grid_link_shreg.sv
// grid_link_shreg: parallel-load shift register, shifts toward the MSB, fills at the LSB.
// Ports: clk, reset (async, active-high), i_load (parallel load, has priority),
//        i_shift (shift one place), i_din (parallel data), i_sin (serial in), o_q (contents).
module grid_link_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_din,
    input  logic         i_sin,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_q <= '0;
        else if (i_load)
            r_q <= i_din;
        else if (i_shift)
            r_q <= {r_q[W-2:0], i_sin};
    end

    assign o_q = r_q;
endmodule

// File: rtl/grid_serial_link.sv
// grid_serial_link: host command controller driving a serial grid memory (LOAD/RUN/READ).
// Ports: clk, reset (async, active-high); host command i_cmd_valid/o_cmd_ready/i_cmd_op/i_cmd_data;
//        readback o_rsp_valid/i_rsp_ready/o_rsp_data; memory side o_serial_in, o_load_mode,
//        o_run_mode, o_output_mode, i_serial_out; status o_busy, o_err_illegal.
// Option: GRID_LINK_GEN_COUNT_EN adds o_gen_count, a 16-bit count of run_mode cycles
//         cleared by every completed LOAD.
module grid_serial_link
    import grid_link_pkg::*;
#(
    parameter int DATA_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [1:0]           i_cmd_op,
    input  logic [DATA_SIZE-1:0] i_cmd_data,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [DATA_SIZE-1:0] o_rsp_data,
    output logic                 o_serial_in,
    output logic                 o_load_mode,
    output logic                 o_run_mode,
    output logic                 o_output_mode,
    input  logic                 i_serial_out,
    output logic                 o_busy,
    output logic                 o_err_illegal
`ifdef GRID_LINK_GEN_COUNT_EN
    ,
    output logic [RUN_W-1:0]     o_gen_count
`endif
);
    localparam int CW = $clog2(DATA_SIZE + 1);

    state_e             r_state, w_state_nx;
    logic [CW-1:0]      r_cnt, w_cnt_nx;
    logic [RUN_W-1:0]   r_run, w_run_nx;
    logic               r_cmd_ready, r_rsp_valid, r_load_mode, r_run_mode, r_output_mode;
    logic               r_busy, r_err, r_cap;
    logic               w_accept, w_tx_load, w_err_nx;
    logic [DATA_SIZE-2:0] w_tx_unused;
    op_e                w_op;

    assign w_op     = op_e'(i_cmd_op);
    assign w_accept = i_cmd_valid && r_cmd_ready;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_run_nx   = r_run;
        w_tx_load  = 1'b0;
        w_err_nx   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_LOAD: begin
                            w_state_nx = S_LOAD;
                            w_cnt_nx   = CW'(DATA_SIZE);
                            w_tx_load  = 1'b1;
                        end
                        OP_RUN: begin
                            w_run_nx   = RUN_W'(i_cmd_data);
                            w_state_nx = (RUN_W'(i_cmd_data) == '0) ? S_IDLE : S_RUN;
                        end
                        OP_READ: begin
                            w_state_nx = S_READ;
                            w_cnt_nx   = CW'(DATA_SIZE);
                        end
                        default: w_err_nx = 1'b1;
                    endcase
                end
            end
            S_LOAD: begin
                w_cnt_nx   = r_cnt - 1'b1;
                w_state_nx = (r_cnt == CW'(1)) ? S_IDLE : S_LOAD;
            end
            S_RUN: begin
                w_run_nx   = r_run - 1'b1;
                w_state_nx = (r_run == RUN_W'(1)) ? S_IDLE : S_RUN;
            end
            S_READ: begin
                w_cnt_nx   = r_cnt - 1'b1;
                w_state_nx = (r_cnt == CW'(1)) ? S_DRAIN : S_READ;
            end
            // the last memory bit arrives one cycle after output_mode drops
            S_DRAIN: w_state_nx = S_RESP;
            S_RESP:  w_state_nx = i_rsp_ready ? S_IDLE : S_RESP;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_run         <= '0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_load_mode   <= 1'b0;
            r_run_mode    <= 1'b0;
            r_output_mode <= 1'b0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
            r_cap         <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_run         <= w_run_nx;
            r_cmd_ready   <= (w_state_nx == S_IDLE);
            r_rsp_valid   <= (w_state_nx == S_RESP);
            r_load_mode   <= (w_state_nx == S_LOAD);
            r_run_mode    <= (w_state_nx == S_RUN);
            r_output_mode <= (w_state_nx == S_READ);
            r_busy        <= (w_state_nx != S_IDLE);
            r_err         <= w_err_nx;
            // memory presents each bit one cycle after output_mode requested it
            r_cap         <= r_output_mode;
        end
    end

    // TX fills with zeros, so its MSB is exactly the serial_in bit during LOAD and 0 otherwise
    grid_link_shreg #(.W(DATA_SIZE)) u_tx (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_tx_load),
        .i_shift (r_state == S_LOAD),
        .i_din   (i_cmd_data),
        .i_sin   (1'b0),
        .o_q     ({o_serial_in, w_tx_unused})
    );

    grid_link_shreg #(.W(DATA_SIZE)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .i_load  (1'b0),
        .i_shift (r_cap),
        .i_din   ('0),
        .i_sin   (i_serial_out),
        .o_q     (o_rsp_data)
    );

`ifdef GRID_LINK_GEN_COUNT_EN
    logic [RUN_W-1:0] r_gen_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_gen_count <= '0;
        else if (r_state == S_LOAD && r_cnt == CW'(1))
            r_gen_count <= '0;
        else if (r_run_mode)
            r_gen_count <= r_gen_count + 1'b1;
    end

    assign o_gen_count = r_gen_count;
`endif

    assign o_cmd_ready   = r_cmd_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_load_mode   = r_load_mode;
    assign o_run_mode    = r_run_mode;
    assign o_output_mode = r_output_mode;
    assign o_busy        = r_busy;
    assign o_err_illegal = r_err;
endmodule

// File: tb/tb_grid_serial_link.sv
// tb_grid_serial_link: randomized self-checking bench with a behavioural grid memory and reference.
module tb_grid_serial_link;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic [1:0]    i_cmd_op = '0;
    logic [DW-1:0] i_cmd_data = '0;
    logic          i_rsp_ready = 1'b0;
    logic          o_cmd_ready, o_rsp_valid;
    logic [DW-1:0] o_rsp_data;
    logic          o_serial_in, o_load_mode, o_run_mode, o_output_mode;
    logic          i_serial_out;
    logic          o_busy, o_err_illegal;
`ifdef GRID_LINK_GEN_COUNT_EN
    logic [15:0]   o_gen_count;
    logic [15:0]   exp_gen = '0;
`endif

    // grid memory: LOAD shifts in at LSB, RUN advances one generation (+1), READ rotates out MSB
    logic [DW-1:0] mem_q = '0;
    logic          mem_sout = 1'b0;
    logic [DW-1:0] exp_mem = '0;
    int            n_tests = 0;
    int            n_fail = 0;

    assign i_serial_out = mem_sout;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_load_mode)
            mem_q <= {mem_q[DW-2:0], o_serial_in};
        else if (o_run_mode)
            mem_q <= mem_q + 1'b1;
        else if (o_output_mode) begin
            mem_sout <= mem_q[DW-1];
            mem_q    <= {mem_q[DW-2:0], mem_q[DW-1]};
        end
    end

    grid_serial_link #(.DATA_SIZE(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_op      (i_cmd_op),
        .i_cmd_data    (i_cmd_data),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_data    (o_rsp_data),
        .o_serial_in   (o_serial_in),
        .o_load_mode   (o_load_mode),
        .o_run_mode    (o_run_mode),
        .o_output_mode (o_output_mode),
        .i_serial_out  (i_serial_out),
        .o_busy        (o_busy),
        .o_err_illegal (o_err_illegal)
`ifdef GRID_LINK_GEN_COUNT_EN
        ,
        .o_gen_count   (o_gen_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_gen();
`ifdef GRID_LINK_GEN_COUNT_EN
        check("gen_count", o_gen_count, exp_gen);
`endif
    endtask

    task automatic run_op(input int op, input logic [DW-1:0] d, input int hold);
        int wait_n = 0, cyc = 0, loads = 0, runs = 0, outs = 0, errs = 0;
        int overlap = 0, stray = 0, valids = 0, unstable = 0, rdy_busy = 0;
        logic [DW-1:0] sin_bits = '0, first_rsp = '0;
        while (!o_cmd_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check("cmd_ready_wait", wait_n < 50, 1);
        i_cmd_valid = 1'b1;
        i_cmd_op    = op[1:0];
        i_cmd_data  = d;
        i_rsp_ready = 1'b0;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        i_cmd_data  = DW'($urandom);
        i_cmd_op    = 2'($urandom);
        forever begin
            if (o_err_illegal) errs++;
            if (o_load_mode) begin
                sin_bits = {sin_bits[DW-2:0], o_serial_in};
                loads++;
            end else if (o_serial_in) stray++;
            if (o_run_mode) runs++;
            if (o_output_mode) outs++;
            if (int'(o_load_mode) + int'(o_run_mode) + int'(o_output_mode) > 1) overlap++;
            if (o_cmd_ready && o_busy) rdy_busy++;
            if (o_rsp_valid) begin
                if (valids == 0) first_rsp = o_rsp_data;
                else if (o_rsp_data !== first_rsp) unstable++;
                valids++;
                if (valids == hold + 1) i_rsp_ready = 1'b1;
            end
            if (!o_busy || cyc >= 400) break;
            @(negedge clk);
            cyc++;
        end
        i_rsp_ready = 1'b0;
        check("op_timeout", cyc < 400, 1);
        check("mode_overlap", overlap, 0);
        check("serial_in_idle", stray, 0);
        check("ready_while_busy", rdy_busy, 0);
        case (op)
            0: begin
                check("load_cycles", loads, DW);
                check("serial_in_bits", sin_bits, d);
                exp_mem = d;
                check("mem_after_load", mem_q, exp_mem);
`ifdef GRID_LINK_GEN_COUNT_EN
                exp_gen = '0;
`endif
            end
            1: begin
                check("run_cycles", runs, d);
                exp_mem = exp_mem + d;
                check("mem_after_run", mem_q, exp_mem);
`ifdef GRID_LINK_GEN_COUNT_EN
                exp_gen = exp_gen + 16'(d);
`endif
            end
            2: begin
                check("read_cycles", outs, DW);
                check("rsp_data", first_rsp, exp_mem);
                check("rsp_valid_cycles", valids, hold + 1);
                check("rsp_stable", unstable, 0);
            end
            default: begin
                check("err_pulses", errs, 1);
                check("illegal_modes", loads + runs + outs, 0);
            end
        endcase
        if (op != 3) check("err_none", errs, 0);
        if (op != 2) check("rsp_none", valids, 0);
        check("idle_ready", o_cmd_ready, 1);
        check_gen();
    endtask

    initial begin
        int k;
        logic [DW-1:0] d;
        #1 reset = 1'b1;
        #2;
        check("rst_cmd_ready", o_cmd_ready, 0);
        check("rst_busy", o_busy, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_data", o_rsp_data, 0);
        check("rst_modes", {o_load_mode, o_run_mode, o_output_mode, o_serial_in, o_err_illegal}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", o_cmd_ready, 1);
        check_gen();

        run_op(0, 8'hA5, 0);
        run_op(1, 8'd3, 0);
        run_op(1, 8'd0, 0);
        run_op(0, 8'h3C, 0);
        run_op(2, 8'h00, 0);
        run_op(2, 8'h00, 5);
        run_op(3, 8'h5A, 0);

        // reset during the fourth LOAD bit: three bits reach the memory, no response follows
        d = 8'h96;
        i_cmd_valid = 1'b1;
        i_cmd_op    = 2'd0;
        i_cmd_data  = d;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        k = 1;
        while (k < 4) begin
            @(negedge clk);
            k++;
        end
        check("load_before_reset", o_load_mode, 1);
        reset = 1'b1;
        #1;
        check("midrst_modes", {o_load_mode, o_run_mode, o_output_mode, o_serial_in}, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_ready", o_cmd_ready, 0);
        exp_mem = (exp_mem << 3) | (d >> 5);
`ifdef GRID_LINK_GEN_COUNT_EN
        exp_gen = '0;
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", o_cmd_ready, 1);
        check("post_rst_rsp_valid", o_rsp_valid, 0);
        run_op(2, 8'h00, 1);

        for (int i = 0; i < 40; i++) begin
            int op;
            op = int'($urandom_range(0, 3));
            d  = (op == 1) ? DW'($urandom_range(0, 20)) : DW'($urandom);
            run_op(op, d, int'($urandom_range(0, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/grid_serial_link.md
GRID_SERIAL_LINK -- requirements
Module: grid_serial_link

Interface
REQ-001 Parameter DATA_SIZE, default 64, SHALL set grid word width in bits (minimum 2).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 cmd_valid  input  1  host command valid.
REQ-005 cmd_ready  output  1  controller accepts command this cycle.
REQ-006 cmd_op  input  2  operation: 0 LOAD, 1 RUN, 2 READ, 3 illegal.
REQ-007 cmd_data  input  DATA_SIZE  LOAD grid word; RUN count in bits [15:0].
REQ-008 rsp_valid  output  1  readback word valid.
REQ-009 rsp_ready  input  1  host accepts readback word.
REQ-010 rsp_data  output  DATA_SIZE  captured grid word.
REQ-011 serial_in, load_mode, run_mode, output_mode  output  1 each  drive the grid memory's like-named inputs.
REQ-012 serial_out  input  1  serial data from grid memory.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 err_illegal  output  1  one-cycle pulse on acceptance of op 3.

Function
REQ-015 The controller SHALL implement states IDLE, LOAD, RUN, READ, DRAIN, RESP; all outputs SHALL be registered.
REQ-016 cmd_ready SHALL be high only in IDLE; a command SHALL be accepted on a rising edge with cmd_valid and cmd_ready both high.
REQ-017 LOAD SHALL assert load_mode for exactly DATA_SIZE consecutive cycles, starting the cycle after acceptance; serial_in SHALL carry cmd_data MSB first, one bit per cycle, so that after the last cycle the memory holds cmd_data unchanged.
REQ-018 RUN with count N>0 SHALL assert run_mode for exactly N consecutive cycles; N=0 SHALL return to IDLE the cycle after acceptance with no run_mode cycle.
REQ-019 READ SHALL assert output_mode for exactly DATA_SIZE consecutive cycles, then enter DRAIN for one cycle.
REQ-020 A serial_out bit SHALL be captured on every rising edge where output_mode was high in the preceding cycle (one-cycle memory lag), shifting into rsp_data LSB so the first captured bit ends at the MSB.
REQ-021 After the DATA_SIZE-th capture the controller SHALL enter RESP with rsp_valid high and rsp_data stable until rsp_ready is sampled high, then return to IDLE.
REQ-022 At most one of load_mode, run_mode, output_mode SHALL be high in any cycle; all three SHALL be low in IDLE, DRAIN and RESP.
REQ-023 Op 3 SHALL be accepted, pulse err_illegal for one cycle, and leave state IDLE with no mode asserted.
REQ-024 cmd_data SHALL be sampled only at acceptance; changes afterwards SHALL not affect the operation in progress.
REQ-025 serial_in SHALL be 0 whenever load_mode is low.

Reset
REQ-026 Reset SHALL force state IDLE, all outputs 0 (rsp_data 0, cmd_ready 1 after reset release), all counters 0, including mid-operation; a partial LOAD or READ SHALL be abandoned without response.

Configuration
REQ-027 With GRID_LINK_GEN_COUNT_EN defined, an extra output gen_count (16 bits) SHALL increment once per run_mode cycle, wrap from 16'hFFFF to 0, reset to 0, and clear to 0 on each completed LOAD; without the macro the port and counter SHALL not exist and behaviour is otherwise identical.

Structure
REQ-028 Package grid_link_pkg SHALL hold the op enum typedef, the state enum typedef and the RUN count width constant (16).
REQ-029 One sub-module grid_link_shreg (parameterised parallel-load, serial shift register, MSB out, LSB in) SHALL be instantiated twice: TX for LOAD data, RX for capture.
REQ-030 Bit counter width SHALL be $clog2(DATA_SIZE+1).

Verification
REQ-031 DATA_SIZE=8, LOAD 8'hA5 -> load_mode high 8 cycles, serial_in 1,0,1,0,0,1,0,1; memory parallel output 8'hA5.
REQ-032 LOAD 8'h3C then READ with memory model -> output_mode high 8 cycles, rsp_valid after DRAIN, rsp_data 8'h3C.
REQ-033 READ with rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable 5 cycles, cmd_ready low until handshake.
REQ-034 RUN N=3 then RUN N=0 -> run_mode high exactly 3 cycles, then none; gen_count 3 when macro defined.
REQ-035 Reset asserted at LOAD bit 4 -> all outputs 0 immediately, IDLE after release, next READ returns memory contents with no stale response.
REQ-036 cmd_op=3 -> err_illegal single pulse, no mode asserted, cmd_ready high next cycle.
